// File: rtl/ahbl_axi_wr_seq.sv
// ahbl_axi_wr_seq: sequences one AXI INCR write burst (AW, W beats, B) per command.
// Define AHBL2AXI_WR_OVERLAP_EN to let W beats flow while AW is still pending;
// by default W waits for the AW handshake.
module ahbl_axi_wr_seq #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 64
) (
    input  logic                HCLK,
    input  logic                HRESETN,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [AWIDTH-1:0]   CMD_ADDR,
    input  logic [3:0]          CMD_LEN,
    input  logic [2:0]          CMD_SIZE,
    input  logic                WBUF_EMPTY,
    input  logic [DWIDTH-1:0]   WBUF_DATA,
    input  logic [DWIDTH/8-1:0] WBUF_STRB,
    output logic                WBUF_POP,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [AWIDTH-1:0]   AWADDR,
    output logic [3:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DWIDTH-1:0]   WDATA,
    output logic [DWIDTH/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    input  logic [1:0]          BRESP,
    output logic                BREADY,
    output logic                WR_DONE,
    output logic                WR_ERR
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic              wr_done_q, wr_done_d;
    logic              wr_err_q, wr_err_d;
    logic              w_phase, w_hs, last_hs, cmd_hs;
    logic              unused_bresp;
`ifdef AHBL2AXI_WR_OVERLAP_EN
    logic              w_done_q, w_done_d;
`endif

    assign unused_bresp = BRESP[0];

    // Output decode: handshakes and AXI fields from state and registered command
    always_comb begin
`ifdef AHBL2AXI_WR_OVERLAP_EN
        w_phase   = (state_q == S_DATA) | ((state_q == S_ADDR) & ~w_done_q);
`else
        w_phase   = state_q == S_DATA;
`endif
        CMD_READY = (state_q == S_IDLE) & ~wr_done_q;
        AWVALID   = state_q == S_ADDR;
        AWADDR    = addr_q;
        AWLEN     = len_q;
        AWSIZE    = size_q;
        AWBURST   = 2'b01;
        WVALID    = w_phase & ~WBUF_EMPTY;
        WDATA     = WBUF_DATA;
        WSTRB     = WBUF_STRB;
        WLAST     = w_phase & (cnt_q == len_q);
        WBUF_POP  = WVALID & WREADY;
        BREADY    = state_q == S_RESP;
        WR_DONE   = wr_done_q;
        WR_ERR    = wr_err_q;
        w_hs      = WVALID & WREADY;
        last_hs   = w_hs & WLAST;
        cmd_hs    = CMD_VALID & CMD_READY;
    end

    // Next state: command capture, beat counting (stops at LEN), response completion
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        cnt_d     = (w_hs & ~WLAST) ? cnt_q + 4'd1 : cnt_q;
        wr_done_d = 1'b0;
        wr_err_d  = 1'b0;
`ifdef AHBL2AXI_WR_OVERLAP_EN
        w_done_d  = w_done_q;
`endif
        case (state_q)
            S_IDLE: if (cmd_hs) begin
                state_d  = S_ADDR;
                addr_d   = CMD_ADDR;
                len_d    = CMD_LEN;
                size_d   = CMD_SIZE;
                cnt_d    = 4'd0;
`ifdef AHBL2AXI_WR_OVERLAP_EN
                w_done_d = 1'b0;
`endif
            end
`ifdef AHBL2AXI_WR_OVERLAP_EN
            S_ADDR: begin
                if (last_hs) w_done_d = 1'b1;
                if (AWREADY) state_d = (w_done_q | last_hs) ? S_RESP : S_DATA;
            end
`else
            S_ADDR: if (AWREADY) state_d = S_DATA;
`endif
            S_DATA: if (last_hs) state_d = S_RESP;
            default: if (BVALID) begin
                state_d   = S_IDLE;
                wr_done_d = 1'b1;
                wr_err_d  = BRESP[1];
            end
        endcase
    end

    // State registers; async reset returns to IDLE with cleared fields
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
`ifdef AHBL2AXI_WR_OVERLAP_EN
            w_done_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            wr_done_q <= wr_done_d;
            wr_err_q  <= wr_err_d;
`ifdef AHBL2AXI_WR_OVERLAP_EN
            w_done_q  <= w_done_d;
`endif
        end
    end
endmodule

// File: tb/tb_ahbl_axi_wr_seq.sv
// tb_ahbl_axi_wr_seq: scoreboard bench for the AXI write burst sequencer.
module tb_ahbl_axi_wr_seq;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;

    typedef struct packed {logic [DW-1:0] d; logic [SW-1:0] s;} beat_t;
    typedef struct {logic [DW-1:0] d; logic [SW-1:0] s; logic l;} exp_t;

    logic HCLK = 1'b0, HRESETN = 1'b0;
    logic CMD_VALID = 1'b0, CMD_READY;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [3:0] CMD_LEN = '0;
    logic [2:0] CMD_SIZE = '0;
    logic WBUF_EMPTY = 1'b1, WBUF_POP;
    logic [DW-1:0] WBUF_DATA = '0;
    logic [SW-1:0] WBUF_STRB = '0;
    logic AWVALID, AWREADY = 1'b0;
    logic [AW-1:0] AWADDR;
    logic [3:0] AWLEN;
    logic [2:0] AWSIZE;
    logic [1:0] AWBURST;
    logic WVALID, WREADY = 1'b0, WLAST;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic BVALID = 1'b0, BREADY, WR_DONE, WR_ERR;
    logic [1:0] BRESP = 2'b00;

    int tests = 0, fails = 0;
    logic stall = 1'b0;
    beat_t wbuf[$];
    exp_t sb[$];

    logic s_cmd_ready, s_awvalid, s_wvalid, s_wlast, s_pop, s_bready, s_done, s_err;
    logic [AW-1:0] s_awaddr;
    logic [3:0] s_awlen;
    logic [2:0] s_awsize;
    logic [1:0] s_awburst;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;

    int r_beats, r_wlast, r_aw_cycles, r_aw_bad, r_early_w, r_wv_low;
    int r_bready_n, r_bready_cyc, r_done_n, r_done_cyc, r_err_stray;
    logic r_err, r_done_ready, r_post_done, r_post_ready, r_timeout;

    ahbl_axi_wr_seq #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
        .CMD_LEN(CMD_LEN), .CMD_SIZE(CMD_SIZE),
        .WBUF_EMPTY(WBUF_EMPTY), .WBUF_DATA(WBUF_DATA), .WBUF_STRB(WBUF_STRB), .WBUF_POP(WBUF_POP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY), .WR_DONE(WR_DONE), .WR_ERR(WR_ERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void update_buf();
        WBUF_EMPTY = stall || wbuf.size() == 0;
        WBUF_DATA  = wbuf.size() > 0 ? wbuf[0].d : '0;
        WBUF_STRB  = wbuf.size() > 0 ? wbuf[0].s : '0;
    endfunction

    task automatic sample();
        s_cmd_ready = CMD_READY; s_awvalid = AWVALID; s_awaddr = AWADDR; s_awlen = AWLEN;
        s_awsize = AWSIZE; s_awburst = AWBURST; s_wvalid = WVALID; s_wdata = WDATA;
        s_wstrb = WSTRB; s_wlast = WLAST; s_pop = WBUF_POP; s_bready = BREADY;
        s_done = WR_DONE; s_err = WR_ERR;
    endtask

    // One clock: sample mid-cycle, then let the buffer model react to a pop
    task automatic step();
        @(negedge HCLK);
        #1 sample();
        @(posedge HCLK);
        #1;
        if (s_pop && wbuf.size() > 0) wbuf.delete(0);
        update_buf();
    endtask

    task automatic load_burst(input logic [3:0] len);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        exp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            d = {$urandom, $urandom};
            s = 8'($urandom);
            wbuf.push_back({d, s});
            e.d = d; e.s = s; e.l = (i == int'(len));
            sb.push_back(e);
        end
        update_buf();
    endtask

    // Drives one burst end to end; W beats are checked against the scoreboard as they appear
    task automatic run_burst(input logic [AW-1:0] addr, input logic [3:0] len, input logic [1:0] bresp,
                             input int stall_at, input int stall_n, input int aw_delay);
        exp_t e;
        int cyc, stall_left;
        logic aw_done;
        r_beats = 0; r_wlast = 0; r_aw_cycles = 0; r_aw_bad = 0; r_early_w = 0; r_wv_low = 0;
        r_bready_n = 0; r_bready_cyc = -1; r_done_n = 0; r_done_cyc = -1; r_err_stray = 0;
        r_err = 1'b0; r_done_ready = 1'b1;
        load_burst(len);
        CMD_ADDR = addr; CMD_LEN = len; CMD_SIZE = 3'd3; CMD_VALID = 1'b1;
        BRESP = bresp; BVALID = 1'b1; WREADY = 1'b1; AWREADY = (aw_delay == 0);
        aw_done = 1'b0; stall_left = 0; cyc = 0;
        while (r_done_n == 0 && cyc < 200) begin
            step();
            cyc++;
            if (CMD_VALID && s_cmd_ready) CMD_VALID = 1'b0;
            if (s_wvalid && !aw_done) r_early_w++;
            if (s_awvalid) begin
                r_aw_cycles++;
                if (s_awaddr !== addr || s_awlen !== len || s_awsize !== 3'd3 || s_awburst !== 2'b01) r_aw_bad++;
                if (AWREADY) aw_done = 1'b1;
                else if (r_aw_cycles >= aw_delay) AWREADY = 1'b1;
            end
            if (!s_wvalid && r_beats > 0 && r_beats <= int'(len)) r_wv_low++;
            if (s_wvalid && WREADY) begin
                r_beats++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL w_beat: unexpected extra beat %0d, required %0d beats", r_beats, int'(len) + 1);
                end else begin
                    e = sb.pop_front();
                    if ({s_wdata, s_wstrb, s_wlast, s_pop} !== {e.d, e.s, e.l, 1'b1}) begin
                        fails++;
                        $display("FAIL w_beat %0d: got data=%h strb=%h last=%b pop=%b, required data=%h strb=%h last=%b pop=1",
                                 r_beats, s_wdata, s_wstrb, s_wlast, s_pop, e.d, e.s, e.l);
                    end
                end
                if (s_wlast) r_wlast++;
                if (r_beats == stall_at) begin stall = 1'b1; stall_left = stall_n; end
            end else if (stall) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end
            if (s_bready) begin r_bready_n++; r_bready_cyc = cyc; end
            if (s_err && !s_done) r_err_stray++;
            if (s_done) begin r_done_n++; r_done_cyc = cyc; r_err = s_err; r_done_ready = s_cmd_ready; end
            update_buf();
        end
        r_timeout = (r_done_n == 0);
        BVALID = 1'b0; AWREADY = 1'b0;
        step();
        r_post_done = s_done;
        r_post_ready = s_cmd_ready;
    endtask

    task automatic test_reset();
        int bad;
        step();
        tests++;
        if ({s_cmd_ready, s_awvalid, s_wvalid, s_wlast, s_pop, s_bready, s_done, s_err} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy/awv/wv/wl/pop/brdy/done/err=%b, required 10000000",
                     {s_cmd_ready, s_awvalid, s_wvalid, s_wlast, s_pop, s_bready, s_done, s_err});
        end
        tests++;
        if ({s_awaddr, s_awlen, s_awsize, s_awburst} !== {32'h0, 4'h0, 3'h0, 2'b01}) begin
            fails++;
            $display("FAIL reset_aw: got addr=%h len=%h size=%h burst=%b, required 0/0/0/01",
                     s_awaddr, s_awlen, s_awsize, s_awburst);
        end
        HRESETN = 1'b1;
        wbuf.push_back({64'hdead_beef_0000_0001, 8'hff});
        update_buf();
        BVALID = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_awvalid || s_wvalid || s_pop || s_bready || s_done || !s_cmd_ready) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle_quiet: got %0d active cycles without a command, required 0", bad);
        end
        wbuf.delete();
        BVALID = 1'b0; AWREADY = 1'b0;
        update_buf();
    endtask

    task automatic test_basic();
        run_burst(32'h0000_1000, 4'd3, 2'b00, -1, 0, 0);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_wlast), 32'(r_aw_bad), 32'(r_aw_cycles)} !== {1'b0, 32'd4, 32'd1, 32'd0, 32'd1}) begin
            fails++;
            $display("FAIL basic_burst: got timeout=%b beats=%0d wlast=%0d aw_bad=%0d aw_cycles=%0d, required 0/4/1/0/1",
                     r_timeout, r_beats, r_wlast, r_aw_bad, r_aw_cycles);
        end
        tests++;
        if (r_bready_n !== 1 || r_done_cyc !== r_bready_cyc + 1) begin
            fails++;
            $display("FAIL basic_done_timing: got bready_n=%0d done_cyc=%0d bready_cyc=%0d, required 1 and done=bready+1",
                     r_bready_n, r_done_cyc, r_bready_cyc);
        end
        tests++;
        if ({r_err, r_post_done, r_done_ready, r_post_ready} !== 4'b0001 || r_err_stray !== 0) begin
            fails++;
            $display("FAIL basic_done_pulse: got err=%b post_done=%b rdy_at_done=%b rdy_after=%b stray=%0d, required 0/0/0/1/0",
                     r_err, r_post_done, r_done_ready, r_post_ready, r_err_stray);
        end
    endtask

    task automatic test_err_single();
        run_burst(32'h0000_2040, 4'd0, 2'b10, -1, 0, 0);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_wlast), 32'(r_done_n), r_err, r_post_done} !== {1'b0, 32'd1, 32'd1, 32'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL err_single: got timeout=%b beats=%0d wlast=%0d done_n=%0d err=%b post_done=%b, required 0/1/1/1/1/0",
                     r_timeout, r_beats, r_wlast, r_done_n, r_err, r_post_done);
        end
    endtask

    task automatic test_stall();
        run_burst(32'h0000_3000, 4'd7, 2'b00, 2, 3, 0);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_wlast), 32'(r_wv_low)} !== {1'b0, 32'd8, 32'd1, 32'd3}) begin
            fails++;
            $display("FAIL stall: got timeout=%b beats=%0d wlast=%0d wvalid_low=%0d, required 0/8/1/3",
                     r_timeout, r_beats, r_wlast, r_wv_low);
        end
    endtask

    task automatic test_aw_delay();
        run_burst(32'h0000_4000, 4'd3, 2'b00, -1, 0, 5);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_aw_cycles), 32'(r_aw_bad)} !== {1'b0, 32'd4, 32'd6, 32'd0}) begin
            fails++;
            $display("FAIL aw_delay: got timeout=%b beats=%0d aw_cycles=%0d aw_bad=%0d, required 0/4/6/0",
                     r_timeout, r_beats, r_aw_cycles, r_aw_bad);
        end
        tests++;
`ifdef AHBL2AXI_WR_OVERLAP_EN
        if (r_early_w == 0) begin
            fails++;
            $display("FAIL aw_overlap: got %0d W beats before AW handshake, required at least 1", r_early_w);
        end
`else
        if (r_early_w != 0) begin
            fails++;
            $display("FAIL aw_order: got %0d WVALID cycles before AW handshake, required 0", r_early_w);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int beats, cyc;
        load_burst(4'd15);
        CMD_ADDR = 32'h0000_5000; CMD_LEN = 4'd15; CMD_SIZE = 3'd3; CMD_VALID = 1'b1;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 1 && cyc < 50) begin
            step();
            cyc++;
            if (CMD_VALID && s_cmd_ready) CMD_VALID = 1'b0;
            if (s_wvalid && WREADY) beats++;
        end
        #2 HRESETN = 1'b0;
        #1;
        tests++;
        if ({AWVALID, WVALID, WLAST, WBUF_POP, BREADY, WR_DONE, WR_ERR, CMD_READY, AWADDR, AWLEN, AWSIZE, AWBURST}
            !== {7'b0, 1'b1, 32'h0, 4'h0, 3'h0, 2'b01}) begin
            fails++;
            $display("FAIL mid_reset: got awv=%b wv=%b wl=%b pop=%b brdy=%b done=%b err=%b rdy=%b addr=%h len=%h size=%h burst=%b (beats before=%0d), required all 0, rdy=1, burst=01",
                     AWVALID, WVALID, WLAST, WBUF_POP, BREADY, WR_DONE, WR_ERR, CMD_READY, AWADDR, AWLEN, AWSIZE, AWBURST, beats);
        end
        CMD_VALID = 1'b0;
        wbuf.delete();
        sb.delete();
        update_buf();
        step();
        step();
        HRESETN = 1'b1;
        run_burst(32'h0000_6000, 4'd1, 2'b00, -1, 0, 0);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_aw_cycles), 32'(r_aw_bad)} !== {1'b0, 32'd2, 32'd1, 32'd0}) begin
            fails++;
            $display("FAIL after_reset: got timeout=%b beats=%0d aw_cycles=%0d aw_bad=%0d, required 0/2/1/0",
                     r_timeout, r_beats, r_aw_cycles, r_aw_bad);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(32'h0000_7000, 4'd2, 2'b01, -1, 0, 0);
        tests++;
        if ({r_timeout, 32'(r_beats), r_err, r_post_ready} !== {1'b0, 32'd3, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL b2b_first: got timeout=%b beats=%0d err=%b rdy_after=%b, required 0/3/0/1",
                     r_timeout, r_beats, r_err, r_post_ready);
        end
        run_burst(32'h0000_7100, 4'd15, 2'b11, -1, 0, 2);
        tests++;
        if ({r_timeout, 32'(r_beats), 32'(r_wlast), r_err, 32'(r_aw_bad)} !== {1'b0, 32'd16, 32'd1, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL b2b_second: got timeout=%b beats=%0d wlast=%0d err=%b aw_bad=%0d, required 0/16/1/1/0",
                     r_timeout, r_beats, r_wlast, r_err, r_aw_bad);
        end
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d beats never written, required 0", sb.size());
        end
    endtask

    initial begin
        update_buf();
        test_reset();
        test_basic();
        test_err_single();
        test_stall();
        test_aw_delay();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
